// File: rtl/event_axis_streamer_pkg.sv
// Shared types and defaults for the event FIFO to AXI4-Stream packetiser.
// Header layout: {magic[15:0], words per event[15:0], packet sequence number[31:0]}.
package event_axis_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } stream_state_t;

    localparam int          WORDS_PER_EVENT_DEF = 16;
    localparam int          DATA_WIDTH_DEF      = 64;
    localparam logic [15:0] HEADER_MAGIC_DEF    = 16'hE7D0;
    localparam int          SKID_DEPTH          = 2;

    function automatic logic [63:0] pack_header(input logic [15:0] magic,
                                                input logic [15:0] words,
                                                input logic [31:0] seq);
        return {magic, words, seq};
    endfunction

endpackage

// File: rtl/event_axis_streamer_skid.sv
// Two-entry skid buffer between the FIFO read pipeline and the AXI4-Stream master port.
// Latency: one cycle from input push to output valid; outputs come straight from registers.
// Backpressure: in_rdy_o depends only on the spare slot, never combinationally on out_rdy_i.
module event_axis_streamer_skid #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_dat_o,
    input  logic             out_rdy_i,
    output logic [1:0]       count_o
);

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             spare_vld_q, spare_vld_d;
    logic [WIDTH-1:0] spare_dat_q, spare_dat_d;
    logic             push;
    logic             pop;

    assign in_rdy_o  = !spare_vld_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_dat_q;
    assign count_o   = {1'b0, out_vld_q} + {1'b0, spare_vld_q};

    assign push = in_vld_i & in_rdy_o;
    assign pop  = out_vld_q & out_rdy_i;

    // The spare slot only fills while the output register is held, so it is
    // always the older entry and drains into the output register first.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        spare_vld_d = spare_vld_q;
        spare_dat_d = spare_dat_q;
        if (!out_vld_q || pop) begin
            if (spare_vld_q) begin
                out_vld_d   = 1'b1;
                out_dat_d   = spare_dat_q;
                spare_vld_d = 1'b0;
            end else begin
                out_vld_d = push;
                if (push) begin
                    out_dat_d = in_dat_i;
                end
            end
        end else if (push) begin
            spare_vld_d = 1'b1;
            spare_dat_d = in_dat_i;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            spare_vld_q <= 1'b0;
            spare_dat_q <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            spare_vld_q <= spare_vld_d;
            spare_dat_q <= spare_dat_d;
        end
    end

endmodule

// File: rtl/event_axis_streamer.sv
// Drains the event FIFO and emits each event as one header beat plus WORDS_PER_EVENT payload beats.
// Latency: header valid 2 cycles after empty_i falls in IDLE, then one beat per cycle while data and tready allow.
// Backpressure: tready low stalls FIFO reads; the 2-entry skid buffer absorbs the read already in flight.
module event_axis_streamer
    import event_axis_streamer_pkg::*;
#(
    parameter int          WORDS_PER_EVENT = WORDS_PER_EVENT_DEF,
    parameter int          DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter logic [15:0] HEADER_MAGIC    = HEADER_MAGIC_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] dout_i,
    output logic                  rd_en_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           events_sent_o,
    output logic                  busy_o
);

    localparam int               CNT_W    = $clog2(WORDS_PER_EVENT + 1);
    localparam logic [CNT_W-1:0] WORDS    = CNT_W'(WORDS_PER_EVENT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_EVENT - 1);

    stream_state_t    state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [31:0]      events_q, events_d;
    logic             inflight_q;
    logic             inflight_last_q;

    logic                  hdr_vld;
    logic                  rd_window;
    logic                  rd_en;
    logic                  skid_in_vld;
    logic [DATA_WIDTH:0]   skid_in_dat;
    logic                  skid_in_rdy;
    logic                  skid_out_vld;
    logic [DATA_WIDTH:0]   skid_out_dat;
    logic [1:0]            skid_count;
    logic                  push_acc;
    logic                  beat_pop;
    logic [2:0]            occ_next;
    logic [DATA_WIDTH-1:0] header_word;

    assign header_word = DATA_WIDTH'(pack_header(HEADER_MAGIC, 16'(WORDS_PER_EVENT), events_q));
    assign beat_pop    = skid_out_vld & m_axis_tready;

    // The first payload read is issued while the header is being pushed, so the
    // payload beats follow the header back-to-back. A read is only issued when the
    // skid buffer is guaranteed a free slot on the cycle its data returns.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        events_d  = events_q;
        hdr_vld   = 1'b0;
        rd_window = 1'b0;
        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (!empty_i) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                hdr_vld   = 1'b1;
                rd_window = skid_in_rdy;
                if (skid_in_rdy) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd_window = 1'b1;
                if (rd_cnt_q == WORDS) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (beat_pop && m_axis_tlast) begin
                    state_d  = IDLE;
                    events_d = events_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        skid_in_vld = hdr_vld | inflight_q;
        skid_in_dat = inflight_q ? {inflight_last_q, dout_i} : {1'b0, header_word};
        push_acc    = skid_in_vld & skid_in_rdy;
        occ_next    = {1'b0, skid_count} + {2'b00, push_acc} - {2'b00, beat_pop};

        rd_en = rd_window & !empty_i & (rd_cnt_q < WORDS) & (occ_next < 3'd2);
        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            rd_cnt_q        <= '0;
            events_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            events_q        <= events_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & (rd_cnt_q == LAST_IDX);
        end
    end

    event_axis_streamer_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_vld_i  (skid_in_vld),
        .in_dat_i  (skid_in_dat),
        .in_rdy_o  (skid_in_rdy),
        .out_vld_o (skid_out_vld),
        .out_dat_o (skid_out_dat),
        .out_rdy_i (m_axis_tready),
        .count_o   (skid_count)
    );

    assign rd_en_o       = rd_en;
    assign m_axis_tvalid = skid_out_vld;
    assign m_axis_tdata  = skid_out_dat[DATA_WIDTH-1:0];
    assign m_axis_tlast  = skid_out_dat[DATA_WIDTH];
    assign events_sent_o = events_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_event_axis_streamer.sv
// Bench for event_axis_streamer: FIFO model with 1-cycle read latency, random tready,
// and a beat scoreboard filled as events are written into the FIFO.
module tb_event_axis_streamer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        empty_i;
    logic [63:0] dout_i = '0;
    logic        rd_en_o;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] events_sent_o;
    logic        busy_o;

    always #5 clk = ~clk;

    event_axis_streamer dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .empty_i       (empty_i),
        .dout_i        (dout_i),
        .rd_en_o       (rd_en_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .events_sent_o (events_sent_o),
        .busy_o        (busy_o)
    );

    // FIFO model: words written by the stimulus, popped on rd_en_o, data one cycle later.
    logic [63:0] mem [0:511];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_clr = 1'b0;
    int          cyc = 0;

    assign empty_i = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en_o && (rd_ptr != wr_ptr)) begin
            dout_i <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int           checks = 0;
    int           errors = 0;
    logic [64:0]  exp_q [$];
    int           rdy_mode = 0;
    int           pkt_beat = 0;
    int           pkt_start = 0;
    int           last_cyc = 0;
    int           last_gap = 0;
    int           max_span = 0;
    logic         stall_q = 1'b0;
    logic [63:0]  stall_dat = '0;
    logic         stall_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_event(input logic [31:0] seq, input logic [63:0] base);
        exp_q.push_back({1'b0, 16'hE7D0, 16'd16, seq});
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), base + 64'(i)});
        end
    endtask

    task automatic put_words(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 64'(i);
            wr_ptr++;
        end
    endtask

    task automatic mon_step();
        logic [64:0] e;
        if (!aresetn) begin
            stall_q  = 1'b0;
            pkt_beat = 0;
            return;
        end
        if (rd_en_o) chk("rd_on_empty", 64'(empty_i), 64'd0);
        if (stall_q) begin
            chk("tdata_stable", m_axis_tdata, stall_dat);
            chk("tlast_stable", 64'(m_axis_tlast), 64'(stall_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_axis_tdata, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, e[63:0]);
                chk("beat_last", 64'(m_axis_tlast), 64'(e[64]));
            end
            if (pkt_beat == 0) begin
                last_gap  = cyc - last_cyc;
                pkt_start = cyc;
            end
            if (m_axis_tlast) begin
                if (cyc - pkt_start > max_span) max_span = cyc - pkt_start;
                last_cyc = cyc;
                pkt_beat = 0;
            end else begin
                pkt_beat++;
            end
        end
        stall_q    = m_axis_tvalid && !m_axis_tready;
        stall_dat  = m_axis_tdata;
        stall_last = m_axis_tlast;
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (events_sent_o == 32'(n)) break;
        end
        chk("events_sent", 64'(events_sent_o), 64'(n));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en_o), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
        chk({tag, "_events"}, 64'(events_sent_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int t0;
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #1;
                m_axis_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        // Reset held with data waiting in the FIFO
        exp_event(32'd0, 64'd0);
        put_words(64'd0, 16);
        repeat (4) begin
            @(negedge clk);
            chk_reset_outputs("rst");
        end

        // Single preloaded event at full rate
        @(posedge clk); #1;
        aresetn = 1'b1;
        wait_events(1, 100);
        chk("t2_span", 64'(max_span), 64'd16);
        chk("t2_busy_idle", 64'(busy_o), 64'd0);

        // Two events back-to-back
        @(posedge clk); #1;
        max_span = 0;
        exp_event(32'd1, 64'd100);
        exp_event(32'd2, 64'd200);
        put_words(64'd100, 16);
        put_words(64'd200, 16);
        wait_events(3, 200);
        chk("t3_max_span", 64'(max_span), 64'd16);
        chk("t3_pkt_gap", 64'(last_gap), 64'd3);

        // Random tready and bursty FIFO writes
        @(posedge clk); #1;
        rdy_mode = 1;
        exp_event(32'd3, 64'd300);
        exp_event(32'd4, 64'd400);
        for (int i = 0; i < 32; i++) begin
            put_words((i < 16) ? 64'(300 + i) : 64'(400 + i - 16), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_events(5, 1000);
        rdy_mode = 0;

        // FIFO runs dry mid-packet
        @(posedge clk); #1;
        exp_event(32'd5, 64'd500);
        put_words(64'd500, 8);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t5_gap_busy", 64'(busy_o), 64'd1);
        chk("t5_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t5_gap_events", 64'(events_sent_o), 64'd5);
        @(posedge clk); #1;
        put_words(64'd508, 8);
        wait_events(6, 200);

        // Reset in the middle of a packet
        @(posedge clk); #1;
        exp_event(32'd6, 64'd600);
        put_words(64'd600, 16);
        t0 = 0;
        while (pkt_beat < 6 && t0 < 100) begin
            @(negedge clk);
            t0++;
        end
        chk("t6_reached_beat", 64'(pkt_beat >= 6), 64'd1);
        @(posedge clk); #1;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        exp_q.delete();
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        max_span = 0;
        exp_event(32'd0, 64'd700);
        put_words(64'd700, 16);
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) break;
        end
        chk("t6_hdr_latency", 64'(cyc - t0), 64'd2);
        wait_events(1, 200);
        chk("t6_span", 64'(max_span), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
